// File: rtl/ps2_pkg.sv
// PS/2 host transmitter package: FSM state enum, default timing constants,
// frame length and the parity helper shared by the transmitter blocks.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      BITS,
      STOP,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   // Defaults assume a 50 MHz system clock
   localparam int PS2_INHIBIT_CYCLES = 5000;     // 100 us clock-low inhibit
   localparam int PS2_START_CYCLES   = 250;      // both lines low before clock release
   localparam int PS2_TIMEOUT_CYCLES = 750000;   // 15 ms frame limit
   localparam int PS2_FRAME_BITS     = 11;       // start + 8 data + parity + stop

   // Odd parity: the parity bit makes the count of ones across data+parity odd
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a registered falling-edge
// pulse. A pin change shows up as o_fall three clk cycles later. Reusable by
// the receive decoder.
module ps2_line_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_fall;

   // Synchronize the line, keep the previous level and flag high-to-low transitions
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_line;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_fall <= r_prev & ~r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, presents the start
// bit, then shifts data/parity/stop on device clock falling edges and checks
// the device ACK. Optional macro PS2_TX_RETRY_EN adds up to two automatic
// retries of a failed (NACK or timeout) frame before reporting tx_error.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
   parameter int START_CYCLES   = PS2_START_CYCLES,
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   input  logic       i_ps2_clk_in,
   input  logic       i_ps2_dat_in,
   output logic       o_ps2_clk_oe,
   output logic       o_ps2_dat_oe,
   output logic       o_busy,
   output logic       o_tx_done,
   output logic       o_tx_error
);

   localparam int CMAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

   ps2_state_e      r_state;
   logic [CW-1:0]   r_cnt;
   logic [TW-1:0]   r_tmo;
   logic [3:0]      r_bit;
   logic [7:0]      r_data;
   logic            r_par;
   logic            r_clk_oe;
   logic            r_dat_oe;
   logic            r_done;
   logic            r_err;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]      r_retry;
`endif

   logic w_clk_lvl;
   logic w_clk_fall;
   logic w_dat_lvl;
   logic w_unused_dat_fall;
   logic w_timed;
   logic w_tmo;
   logic w_nack;
   logic w_fail;

   ps2_line_sync u_clk_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_line  (i_ps2_clk_in),
      .o_level (w_clk_lvl),
      .o_fall  (w_clk_fall)
   );

   ps2_line_sync u_dat_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_line  (i_ps2_dat_in),
      .o_level (w_dat_lvl),
      .o_fall  (w_unused_dat_fall)
   );

   // A frame fails on NACK at the 11th edge or when the device stalls past the limit
   assign w_timed = (r_state == BITS) || (r_state == STOP) || (r_state == ACK) || (r_state == WAIT_IDLE);
   assign w_tmo   = w_timed && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
   assign w_nack  = (r_state == ACK) && w_clk_fall && w_dat_lvl;
   assign w_fail  = w_tmo || w_nack;

   // Frame sequencer: state, line drivers, counters and completion pulses
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_tmo    <= '0;
         r_bit    <= '0;
         r_data   <= '0;
         r_par    <= 1'b0;
         r_clk_oe <= 1'b0;
         r_dat_oe <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         r_retry  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (w_timed) r_tmo <= r_tmo + 1'b1;

         if (w_fail) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (r_retry != 2'd2) begin
               // Re-inhibit with the latched byte; busy stays high
               r_retry  <= r_retry + 1'b1;
               r_clk_oe <= 1'b1;
               r_cnt    <= '0;
               r_state  <= INHIBIT;
            end else begin
               r_err   <= 1'b1;
               r_state <= IDLE;
            end
`else
            r_err   <= 1'b1;
            r_state <= IDLE;
`endif
         end else begin
            case (r_state)
               IDLE: begin
                  if (i_tx_valid) begin
                     r_data   <= i_tx_data;
                     r_par    <= odd_parity(i_tx_data);
                     r_clk_oe <= 1'b1;
                     r_dat_oe <= 1'b0;
                     r_cnt    <= '0;
`ifdef PS2_TX_RETRY_EN
                     r_retry  <= '0;
`endif
                     r_state  <= INHIBIT;
                  end
               end
               INHIBIT: begin
                  if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                     r_cnt    <= '0;
                     r_dat_oe <= 1'b1;          // start bit 0, clock still held
                     r_state  <= START;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               START: begin
                  if (r_cnt == CW'(START_CYCLES - 1)) begin
                     r_clk_oe <= 1'b0;          // hand the clock to the device
                     r_tmo    <= '0;
                     r_bit    <= '0;
                     r_state  <= BITS;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               BITS: begin
                  if (w_clk_fall) begin
                     r_bit <= r_bit + 1'b1;
                     if (r_bit < 4'd8) begin
                        r_dat_oe <= ~r_data[r_bit[2:0]];
                     end else if (r_bit == 4'd8) begin
                        r_dat_oe <= ~r_par;
                     end else begin
                        r_dat_oe <= 1'b0;       // stop bit: release data
                        r_state  <= STOP;
                     end
                  end
               end
               STOP: r_state <= ACK;
               ACK: begin
                  if (w_clk_fall) r_state <= WAIT_IDLE;   // data low here: ACK
               end
               WAIT_IDLE: begin
                  if (w_clk_lvl && w_dat_lvl) begin
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_tx_ready   = (r_state == IDLE);
   assign o_busy       = (r_state != IDLE);
   assign o_ps2_clk_oe = r_clk_oe;
   assign o_ps2_dat_oe = r_dat_oe;
   assign o_tx_done    = r_done;
   assign o_tx_error   = r_err;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 Parameter START_CYCLES, default 250, time both lines are held low before clock release.
REQ-003 Parameter TIMEOUT_CYCLES, default 750000, 15 ms limit from clock release to the end of WAIT_IDLE.
REQ-004 clk  in  1  system clock (CLOCK_50), the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tx_data  in  8  command byte to send to the device.
REQ-007 tx_valid  in  1  request; the byte is accepted when tx_valid&&tx_ready.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 ps2_clk_in / ps2_dat_in  in  1 each  raw asynchronous PS/2 line levels.
REQ-010 ps2_clk_oe / ps2_dat_oe  out  1 each  1 = drive the line low; 0 = release it (open-drain at top level).
REQ-011 busy  out  1  high whenever the state is not IDLE; the top level gates the ps2_decoder with it.
REQ-012 tx_done / tx_error  out  1 each  one-cycle completion pulses.

Function
REQ-013 Lines SHALL be synchronized by two flops, and a PS/2 clock falling edge is detected on the synchronized value; the edge is visible 3 cycles after the pin changes.
REQ-014 The FSM SHALL have the states IDLE, INHIBIT, START, BITS, STOP, ACK, WAIT_IDLE.
REQ-015 On acceptance, the block SHALL latch tx_data, compute odd parity (~^tx_data) and enter INHIBIT, with ps2_clk_oe=1 from the next cycle.
REQ-016 INHIBIT SHALL last exactly INHIBIT_CYCLES cycles and then enter START, which sets ps2_dat_oe=1 (start bit 0) with the clock still held.
REQ-017 After START_CYCLES, the FSM SHALL set ps2_clk_oe=0, clear the timeout counter, and enter BITS.
REQ-018 In BITS, on each falling edge n=1..8, ps2_dat_oe SHALL be set to ~tx_data[n-1], LSB first.
REQ-019 The 9th falling edge SHALL drive ~parity.
REQ-020 The 10th falling edge SHALL release data (stop bit) and enter STOP.
REQ-021 At the 11th falling edge, in ACK, synchronized data==0 SHALL mean ACK; data==1 SHALL mean NACK.
REQ-022 After ACK, the FSM SHALL enter WAIT_IDLE until both synchronized lines are high, then pulse tx_done and return to IDLE.
REQ-023 A NACK SHALL pulse tx_error (subject to REQ-030) and return to IDLE with both lines released.
REQ-024 If the timeout counter reaches TIMEOUT_CYCLES in BITS, STOP, ACK or WAIT_IDLE, the FSM SHALL release both lines, pulse tx_error and go to IDLE.
REQ-025 tx_valid while busy SHALL be ignored; no queueing.
REQ-026 tx_done and tx_error SHALL never be asserted in the same cycle.
REQ-027 Falling edges seen in IDLE, INHIBIT or START SHALL be ignored.

Reset
REQ-028 On any clk edge with reset=1, the block SHALL set state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=1, clear all counters and synchronizers to 1, and abort any frame in progress immediately.

Configuration
REQ-029 Macro PS2_TX_RETRY_EN SHALL select automatic retry.
REQ-030 With PS2_TX_RETRY_EN defined, a NACK or timeout SHALL restart from INHIBIT with the latched byte, up to 2 retries; tx_error SHALL pulse only after the 3rd failure, and busy SHALL stay high throughout.
REQ-031 Without PS2_TX_RETRY_EN, the first failure SHALL pulse tx_error, and no retry counter exists.

Structure
REQ-032 Package ps2_pkg SHALL hold the FSM state enum, the default cycle constants, and the frame bit count (11).
REQ-033 Sub-module ps2_line_sync (2-flop sync + falling-edge pulse) SHALL be instantiated once per line; it is reusable by the decoder.

Verification
REQ-034 Send 0xED with the device model ACKing: 5000 cycles clk_oe=1, data bits 1,0,1,1,0,1,1,1, parity 1; tx_done pulses once after the lines idle.
REQ-035 Send 0xF4: parity bit 0; the frame on the wire is start 0, bits 0010 1111, parity 0, stop 1; tx_done pulses.
REQ-036 Device NACKs 0x00 (parity 1): tx_error pulses, tx_done does not, and both oe are 0 the next cycle.
REQ-037 Device never clocks: tx_error exactly TIMEOUT_CYCLES after clock release; with PS2_TX_RETRY_EN, 3 inhibit phases occur and then a single tx_error.
REQ-038 Reset asserted at the 5th data bit: both oe are 0 and tx_ready=1 after that edge; a new 0xF4 request then completes normally.
REQ-039 tx_valid pulsed during BITS with 0x55: ignored, and only the original byte appears on the wire.
